// File: rtl/vote_logger_n.sv
// Per-ballot vote accumulator: arm/vote/lockout session FSM, saturating counters and registered readout.
// Optional leader/tie tracking is compiled in when VOTE_LOGGER_LEADER_EN is defined.
module vote_logger_n #(
    parameter int unsigned NUM_CAND    = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TOT_W       = 10,
    parameter int unsigned LOCK_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mode,
    input  logic                          ballot_arm,
    input  logic [NUM_CAND-1:0]           vote_valid,
    output logic                          vote_ack,
    output logic                          vote_err,
    output logic                          armed,
    output logic                          sat_flag,
    output logic [NUM_CAND*CNT_W-1:0]     cand_vote_rec,
    output logic [TOT_W-1:0]              total_votes,
    input  logic [$clog2(NUM_CAND)-1:0]   rd_sel,
    output logic [CNT_W-1:0]              rd_count
`ifdef VOTE_LOGGER_LEADER_EN
    ,
    output logic [$clog2(NUM_CAND)-1:0]   leader_idx,
    output logic                          leader_tie
`endif
);

    localparam int unsigned SEL_W = $clog2(NUM_CAND);
    localparam int unsigned LK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [LK_W-1:0]       lock_cnt;
    logic [CNT_W-1:0]      cnt [NUM_CAND];
    logic                  accept, reject;
    logic                  one_hot, multi;
    logic                  sat_hit;
    logic [CNT_W-1:0]      rd_next;

    // Exactly-one / two-or-more press detection without a full popcount.
    assign multi   = (vote_valid & (vote_valid - NUM_CAND'(1))) != '0;
    assign one_hot = (vote_valid != '0) && !multi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (ballot_arm && !mode) state_next = ARMED;
            end
            ARMED: begin
                if (!mode) begin
                    if (one_hot) begin
                        accept     = 1'b1;
                        state_next = LOCK;
                    end else if (multi) begin
                        reject = 1'b1;
                    end
                end
            end
            LOCK: begin
                if (lock_cnt == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lockout down-counter: loaded on acceptance so LOCK lasts LOCK_CYCLES cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (accept) begin
            lock_cnt <= LK_W'(LOCK_CYCLES - 1);
        end else if (state == LOCK && lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LK_W'(1);
        end
    end

    // Saturation is flagged when a counter or the total reaches its maximum.
    always_comb begin
        sat_hit = 1'b0;
        if (accept) begin
            for (int i = 0; i < int'(NUM_CAND); i++) begin
                if (vote_valid[i] && cnt[i] >= CNT_MAX - CNT_W'(1)) sat_hit = 1'b1;
            end
            if (total_votes >= TOT_MAX - TOT_W'(1)) sat_hit = 1'b1;
        end
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < int'(NUM_CAND); i++) begin
            if (SEL_W'(i) == rd_sel) rd_next = cnt[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CAND); i++) cnt[i] <= '0;
            total_votes <= '0;
            vote_ack    <= 1'b0;
            vote_err    <= 1'b0;
            armed       <= 1'b0;
            sat_flag    <= 1'b0;
            rd_count    <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CAND); i++) begin
                if (accept && vote_valid[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
            end
            if (accept && total_votes != TOT_MAX) total_votes <= total_votes + TOT_W'(1);
            if (sat_hit) sat_flag <= 1'b1;
            vote_ack <= accept;
            vote_err <= reject;
            armed    <= (state_next == ARMED);
            rd_count <= rd_next;
        end
    end

    always_comb begin
        cand_vote_rec = '0;
        for (int i = 0; i < int'(NUM_CAND); i++) cand_vote_rec[i*CNT_W +: CNT_W] = cnt[i];
    end

`ifdef VOTE_LOGGER_LEADER_EN
    logic [SEL_W-1:0] lead_idx_c;
    logic [CNT_W-1:0] lead_max_c;
    logic             lead_tie_c;

    // Lowest index wins among equal maxima; tie if any other index shares the maximum.
    always_comb begin
        lead_idx_c = '0;
        lead_max_c = cnt[0];
        lead_tie_c = 1'b0;
        for (int i = 1; i < int'(NUM_CAND); i++) begin
            if (cnt[i] > lead_max_c) begin
                lead_max_c = cnt[i];
                lead_idx_c = SEL_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_CAND); i++) begin
            if (SEL_W'(i) != lead_idx_c && cnt[i] == lead_max_c) lead_tie_c = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leader_idx <= '0;
            leader_tie <= 1'b1;
        end else begin
            leader_idx <= lead_idx_c;
            leader_tie <= lead_tie_c;
        end
    end
`endif

endmodule

// File: doc/vote_logger_n.md
Name: vote_logger_n

Overview:
Parametrised vote accumulator for the voting machine, generalised to NUM_CAND candidates with CNT_W-bit counters. Adds a per-ballot session FSM: an officer arms one ballot, exactly one valid vote is accepted, then a lockout applies. Also adds multi-press rejection, counter saturation, a running total and a registered readout port. Sits between the button debouncers and the display/result mux.

Parameters:
NUM_CAND, 4, number of candidates (2..16)
CNT_W, 8, width of each per-candidate counter
TOT_W, 10, width of total-votes counter
LOCK_CYCLES, 4, lockout cycles after an accepted vote (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
mode  in  1  0 = voting, 1 = result/readout
ballot_arm  in  1  officer pulse enabling one ballot
vote_valid  in  NUM_CAND  one bit per candidate button (debounced, level)
vote_ack  out  1  1-cycle pulse: vote accepted
vote_err  out  1  1-cycle pulse: multi-press rejected
armed  out  1  high while a ballot is open
sat_flag  out  1  sticky; any counter hit max
cand_vote_rec  out  NUM_CAND*CNT_W  flattened counters, candidate i at bits [i*CNT_W +: CNT_W]
total_votes  out  TOT_W  accepted votes, saturating
rd_sel  in  $clog2(NUM_CAND)  readout select
rd_count  out  CNT_W  registered count of candidate rd_sel

Behaviour:
- Reset (async assert, sync deassert at the consumer): all counters 0, total_votes 0, rd_count 0, vote_ack/vote_err 0, sat_flag 0, state IDLE, armed 0.
- FSM states: IDLE, ARMED, LOCK.
- IDLE: on ballot_arm=1 and mode=0 -> ARMED next edge. ballot_arm is ignored when mode=1.
- ARMED: armed=1. Evaluation applies only when mode=0:
  - popcount(vote_valid)==1: at this edge, increment the selected counter and total_votes, pulse vote_ack, go to LOCK. Counts are visible the cycle after the vote is sampled.
  - popcount>=2: no count, pulse vote_err, stay ARMED. vote_err re-pulses every cycle the condition holds.
  - popcount==0: stay ARMED.
- ARMED with mode=1: votes ignored, remain ARMED.
- LOCK: load down-counter with LOCK_CYCLES-1; decrement each cycle; at 0 -> IDLE. Total LOCK dwell = LOCK_CYCLES cycles.
- ballot_arm in ARMED or LOCK is ignored; no queuing.
- Saturation: a counter at 2^CNT_W-1 holds its value. The vote is still acked and total still increments; sat_flag sets. total_votes holds at 2^TOT_W-1 and also sets sat_flag. sat_flag clears only on reset.
- Readout: rd_count <= counter[rd_sel] every cycle regardless of mode (1-cycle latency). rd_sel >= NUM_CAND gives rd_count 0.
- Reset asserted mid-ARMED or mid-LOCK: immediate return to IDLE. The ballot is lost, counters are cleared, and no ack is issued.

Optional Feature:
VOTE_LOGGER_LEADER_EN
- Defined: adds outputs leader_idx ($clog2(NUM_CAND)) and leader_tie (1), both registered from the current counters with 1-cycle latency after any count change.
  - leader_idx is the lowest index holding the maximum count.
  - leader_tie=1 if any other candidate equals that maximum.
  - Reset values: leader_idx 0, leader_tie 1.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, arm, vote_valid=4'b0100 -> vote_ack one cycle later, cand2 count=1, total=1; armed low for 4 cycles, then IDLE.
- Armed, vote_valid=4'b0011 for 3 cycles then 4'b0001 -> 3 vote_err pulses, then ack; cand0=1, cand1=0, total=1.
- No arm, vote_valid=4'b1000 for 10 cycles -> no ack, all counts 0; ballot_arm during LOCK -> ignored, IDLE after lockout.
- CNT_W=8: 256 armed votes for cand3 -> cand3=255, total=256, sat_flag=1 after the 256th vote.
- Reset asserted asynchronously mid-LOCK with counts nonzero -> all outputs 0 before the next clock edge; state IDLE.
- LEADER_EN: votes cand1,cand2,cand2 -> leader_idx=2, tie=0; one more cand1 -> leader_idx=1, tie=1.
